// File: rtl/rtc_cmd_sequencer.sv
// rtc_cmd_sequencer: emits a latched command byte at fixed points of a
// write-sequence counter and reports completion when the counter reaches
// DONE_COUNT.
// Optional feature: define RTC_SEQ_TIMEOUT_EN to add a watchdog that aborts
// ARMED after TIMEOUT_CYCLES cycles without a listo_escritura pulse.
//
// Handshake: start is a single-cycle request honoured only in IDLE.
// listo_escritura is a single-cycle strobe qualifying cont_escritura.
// done is a level held until ack is seen in DONE. There is no back-pressure.
module rtc_cmd_sequencer #(
  parameter int                DATA_W         = 8,
  parameter int                CNT_W          = 6,
  parameter int                NUM_SLOTS      = 2,
  parameter int                FIRST_SLOT     = 7,
  parameter int                SLOT_STRIDE    = 22,
  parameter int                DONE_COUNT     = 42,
  parameter logic [DATA_W-1:0] CMD_SAVE       = 'hF0,
  parameter logic [DATA_W-1:0] CMD_ALT        = 'hF1,
  parameter int                TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              listo_escritura,
  input  logic [CNT_W-1:0]  cont_escritura,
  input  logic              ack,
  output logic [DATA_W-1:0] bus_out,
  output logic              busy,
  output logic              done,
  output logic              missed,
  output logic              timeout,
  output logic [1:0]        state_dbg
);

  // Slot index must hold 0..NUM_SLOTS inclusive (max 8).
  localparam int IDX_W = 4;
  // Slot targets are computed with headroom so they never wrap.
  localparam int EXT_W = CNT_W + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Reject out-of-range configurations at elaboration.
  if (NUM_SLOTS < 1 || NUM_SLOTS > 8) begin : g_bad_slots
    $error("rtc_cmd_sequencer: NUM_SLOTS must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rtc_cmd_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   cmd_q, cmd_d;
  logic [DATA_W-1:0]   bus_q, bus_d;
  logic [IDX_W-1:0]    slot_idx_q, slot_idx_d;
  logic                missed_q, missed_d;
  logic                timeout_q, timeout_d;

  logic [EXT_W-1:0]    cont_ext;
  logic [EXT_W-1:0]    slot_target;
  logic                slots_left;
  logic                slot_hit;
  logic                done_hit;

`ifdef RTC_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]     wd_q, wd_d;
`endif

  // Counter value at which the next outstanding slot is expected.
  assign cont_ext    = EXT_W'(cont_escritura);
  assign slot_target = EXT_W'(FIRST_SLOT) + EXT_W'(slot_idx_q) * EXT_W'(SLOT_STRIDE);
  assign slots_left  = (slot_idx_q < IDX_W'(NUM_SLOTS));
  assign slot_hit    = listo_escritura && slots_left && (cont_ext == slot_target);
  assign done_hit    = listo_escritura && (cont_ext == EXT_W'(DONE_COUNT));

  // Next-state and datapath decisions; every target defaults to hold.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    bus_d      = bus_q;
    slot_idx_d = slot_idx_q;
    missed_d   = missed_q;
    timeout_d  = 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
    wd_d       = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d      = mode ? CMD_ALT : CMD_SAVE;
          slot_idx_d = '0;
          missed_d   = 1'b0;
          state_d    = S_ARMED;
`ifdef RTC_SEQ_TIMEOUT_EN
          wd_d       = '0;
`endif
        end
      end
      S_ARMED: begin
        // The slot load is applied before the completion check, so a slot
        // landing on DONE_COUNT still counts as emitted.
        if (slot_hit) begin
          bus_d      = cmd_q;
          slot_idx_d = slot_idx_q + IDX_W'(1);
        end
        if (done_hit) begin
          state_d  = S_DONE;
          missed_d = (slot_idx_d < IDX_W'(NUM_SLOTS));
        end
`ifdef RTC_SEQ_TIMEOUT_EN
        if (listo_escritura) begin
          wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_DONE: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with immediate abort on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      bus_q      <= '0;
      slot_idx_q <= '0;
      missed_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      bus_q      <= bus_d;
      slot_idx_q <= slot_idx_d;
      missed_q   <= missed_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef RTC_SEQ_TIMEOUT_EN
  // Watchdog counter: cycles spent in ARMED since entry or last pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign bus_out   = bus_q;
  assign busy      = (state_q == S_ARMED);
  assign done      = (state_q == S_DONE);
  assign missed    = missed_q;
  assign state_dbg = state_q;

`ifndef RTC_SEQ_TIMEOUT_EN
  // Without the watchdog the pulse register never sets; keep it referenced.
  logic unused_timeout_q;
  assign unused_timeout_q = timeout_q;
`endif

endmodule

// File: tb/tb_rtc_cmd_sequencer.sv
// Bench for rtc_cmd_sequencer: two instances (default slots, and a
// three-slot / DONE_COUNT=60 variant) share one stimulus stream; a reference
// model predicts every cycle's outputs and a monitor compares them.
module tb_rtc_cmd_sequencer;

  localparam int FIRST  = 7;
  localparam int STRIDE = 22;
`ifdef RTC_SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       mode;
  logic       listo;
  logic [5:0] cont;
  logic       ack;

  logic [7:0] bus0, bus1;
  logic       busy0, busy1, done0, done1, missed0, missed1, tmo0, tmo1;
  logic [1:0] st0, st1;

  rtc_cmd_sequencer #(.TIMEOUT_CYCLES(TMO)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .listo_escritura(listo), .cont_escritura(cont), .ack(ack),
    .bus_out(bus0), .busy(busy0), .done(done0), .missed(missed0),
    .timeout(tmo0), .state_dbg(st0)
  );

  rtc_cmd_sequencer #(.NUM_SLOTS(3), .DONE_COUNT(60), .TIMEOUT_CYCLES(TMO)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .listo_escritura(listo), .cont_escritura(cont), .ack(ack),
    .bus_out(bus1), .busy(busy1), .done(done1), .missed(missed1),
    .timeout(tmo1), .state_dbg(st1)
  );

  // Scoreboard
  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got bus=%h busy/done/missed/tmo=%b, expected bus=%h busy/done/missed/tmo=%b",
                  name, $time, got[11:4], got[3:0], exp[11:4], exp[3:0]);
  endtask

  // Reference model: transaction-level view per instance
  int         m_nslots[2] = '{2, 3};
  int         m_donec[2]  = '{42, 60};
  logic [7:0] m_cmd[2];
  logic [7:0] m_bus[2];
  int         m_sent[2];
  int         m_quiet[2];
  bit         m_armed[2];
  bit         m_fin[2];
  bit         m_missed[2];
  bit         m_tmo[2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cmd[k] = 8'h00; m_bus[k] = 8'h00; m_sent[k] = 0; m_quiet[k] = 0;
        m_armed[k] = 0; m_fin[k] = 0; m_missed[k] = 0; m_tmo[k] = 0;
      end else begin
        m_tmo[k] = 0;
        if (m_fin[k]) begin
          if (ack) m_fin[k] = 0;
        end else if (m_armed[k]) begin
          if (listo) begin
            m_quiet[k] = 0;
            if (m_sent[k] < m_nslots[k] && int'(cont) == FIRST + m_sent[k] * STRIDE) begin
              m_bus[k] = m_cmd[k];
              m_sent[k]++;
            end
            if (int'(cont) == m_donec[k]) begin
              m_armed[k]  = 0;
              m_fin[k]    = 1;
              m_missed[k] = (m_sent[k] < m_nslots[k]);
            end
          end else begin
`ifdef RTC_SEQ_TIMEOUT_EN
            m_quiet[k]++;
            if (m_quiet[k] == TMO) begin
              m_armed[k] = 0;
              m_tmo[k]   = 1;
            end
`endif
          end
        end else if (start) begin
          m_cmd[k]    = mode ? 8'hF1 : 8'hF0;
          m_sent[k]   = 0;
          m_missed[k] = 0;
          m_quiet[k]  = 0;
          m_armed[k]  = 1;
        end
      end
    end
    exp_q0.push_back({m_bus[0], m_armed[0], m_fin[0], m_missed[0], m_tmo[0]});
    exp_q1.push_back({m_bus[1], m_armed[1], m_fin[1], m_missed[1], m_tmo[1]});
  endtask

  // Monitor: compare outputs mid-cycle against the predicted values
  always @(negedge clk) begin
    if (exp_q0.size() > 0) check("dut2_outputs", {bus0, busy0, done0, missed0, tmo0}, exp_q0.pop_front());
    if (exp_q1.size() > 0) check("dut3_outputs", {bus1, busy1, done1, missed1, tmo1}, exp_q1.pop_front());
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_start(input logic m);
    start = 1'b1; mode = m;
    step();
    start = 1'b0;
  endtask

  task automatic pulse(input int c);
    listo = 1'b1; cont = 6'(c);
    step();
    listo = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; listo = 1'b0; cont = '0; ack = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Mode 0, slots 7 and 29 in order, then completion
    do_start(1'b0);
    idle(1);
    pulse(7);
    idle(1);
    pulse(29);
    pulse(42);
    idle(1);
    do_ack();
    idle(1);

    // Mode 1, out-of-order slot then the first slot, early completion
    do_start(1'b1);
    pulse(29);
    pulse(7);
    pulse(42);
    idle(1);

    // ack together with a write pulse while DONE
    ack = 1'b1; listo = 1'b1; cont = 6'd42;
    step();
    ack = 1'b0; listo = 1'b0;
    idle(1);

    // Asynchronous reset in the middle of ARMED after a load
    do_reset();
    do_start(1'b0);
    pulse(7);
    #1 reset = 1'b1;
    #1;
    check("async_reset_dut2", {bus0, busy0, done0, missed0, tmo0}, 12'h000);
    check("async_reset_dut3", {bus1, busy1, done1, missed1, tmo1}, 12'h000);
    @(negedge clk);
    idle(2);
    reset = 1'b0;
    idle(1);

    // Start with no pulses (watchdog expiry when enabled)
    do_start(1'b1);
    idle(TMO == 16 ? 20 : 20);
    do_reset();

    // Three-slot sequence ending at 60
    do_start(1'b0);
    pulse(7);
    pulse(29);
    pulse(51);
    pulse(60);
    idle(1);
    do_ack();
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      start = ($urandom_range(0, 7) == 0);
      mode  = 1'($urandom_range(0, 1));
      listo = ($urandom_range(0, 2) == 0);
      ack   = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      case (r)
        0: cont = 6'd7;
        1: cont = 6'd29;
        2: cont = 6'd51;
        3: cont = 6'd42;
        4: cont = 6'd60;
        default: cont = 6'($urandom_range(0, 63));
      endcase
      step();
    end
    start = 1'b0; listo = 1'b0; ack = 1'b0;
    idle(2);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
